// File: rtl/sys_cmd_core_pkg.sv
// -----------------------------------------------------------------------------
// sys_cmd_core_pkg
// Shared definitions for the UART command processor: command codes, ALU
// function encoding, FSM state encoding and reset values of the UART
// configuration registers.
// -----------------------------------------------------------------------------
package sys_cmd_core_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // reg2: parity enabled, even parity, prescale 32
    localparam logic [7:0] REG2_RST = 8'h81;
    // reg3: clock division ratio
    localparam logic [7:0] REG3_RST = 8'h20;

    // Encoding 15 is intentionally absent; it yields a zero result.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_MUL   = 4'd2,
        ALU_DIV   = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_NAND  = 4'd6,
        ALU_NOR   = 4'd7,
        ALU_XOR   = 4'd8,
        ALU_XNOR  = 4'd9,
        ALU_CMPEQ = 4'd10,
        ALU_CMPGT = 4'd11,
        ALU_CMPLE = 4'd12,
        ALU_SHR   = 4'd13,
        ALU_SHL   = 4'd14
    } alu_func_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ADDR  = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_ALU_A    = 3'd4,
        ST_ALU_B    = 3'd5,
        ST_ALU_FUNC = 3'd6
    } state_e;

endpackage

// File: rtl/sys_cmd_core_resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Synchronous byte FIFO queuing response bytes for the UART transmitter.
// Pushes while full are dropped; push and pop may occur in the same cycle.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   i_push         write strobe
//   i_push_data    byte to write
//   i_pop_ready    consumer ready; a pop occurs on o_valid && i_pop_ready
//   o_valid        FIFO not empty
//   o_data         head entry (0 while empty)
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = !w_empty && i_pop_ready;

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/sys_cmd_core.sv
// -----------------------------------------------------------------------------
// sys_cmd_core
// UART command processor. Decodes command byte sequences from the UART
// receiver, performs register-file reads/writes and ALU operations, and
// queues response bytes for the UART transmitter.
//
// States:
//   ST_IDLE     | waiting for a command byte; unknown bytes ignored
//   ST_WR_ADDR  | RF write, waiting for ADDR
//   ST_WR_DATA  | RF write, waiting for DATA
//   ST_RD_ADDR  | RF read, waiting for ADDR
//   ST_ALU_A    | ALU with operands, waiting for A (written to reg0)
//   ST_ALU_B    | ALU with operands, waiting for B (written to reg1)
//   ST_ALU_FUNC | waiting for FUNC; result computed from reg0/reg1
//
// Ports:
//   REF_CLK, RST        clock and asynchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_valid   response byte, held until tx_ready
//   tx_ready            transmitter ready
//   cfg_uart, cfg_div   continuous views of reg2 and reg3
// -----------------------------------------------------------------------------
module sys_cmd_core
    import sys_cmd_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_NO     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  REF_CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] cfg_uart,
    output logic [DATA_WIDTH-1:0] cfg_div
);

    localparam int RW = 2 * DATA_WIDTH;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_regs [REG_NO];
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_rd_byte;
    logic                  r_rd_push;
    logic [RW-1:0]         r_alu_res;
    logic                  r_push_lo;
    logic                  r_push_hi;

    logic                  w_addr_ld;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_rd_req;
    logic                  w_alu_go;
    logic [RW-1:0]         w_a;
    logic [RW-1:0]         w_b;
    logic [RW-1:0]         w_alu_res;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_ld   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_rd_req    = 1'b0;
        w_alu_go    = 1'b0;
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    case (rx_data)
                        CMD_RF_WR:   w_state_nxt = ST_WR_ADDR;
                        CMD_RF_RD:   w_state_nxt = ST_RD_ADDR;
                        CMD_ALU_OP:  w_state_nxt = ST_ALU_A;
                        CMD_ALU_NOP: w_state_nxt = ST_ALU_FUNC;
                        default:     w_state_nxt = ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: begin
                    w_addr_ld   = 1'b1;
                    w_state_nxt = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    w_rd_req    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_ALU_A: begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = '0;
                    w_state_nxt = ST_ALU_B;
                end
                ST_ALU_B: begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    w_state_nxt = ST_ALU_FUNC;
                end
                ST_ALU_FUNC: begin
                    w_alu_go    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Register file: one write port shared by RF writes and ALU operands.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            r_wr_addr <= '0;
            for (int i = 0; i < REG_NO; i++) begin
                if (i == 2) begin
                    r_regs[i] <= REG2_RST;
                end else if (i == 3) begin
                    r_regs[i] <= REG3_RST;
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else begin
            if (w_addr_ld) begin
                r_wr_addr <= rx_data[ADDR_WIDTH-1:0];
            end
            if (w_wr_en) begin
                r_regs[w_wr_addr] <= rx_data;
            end
        end
    end

    assign w_a = {{DATA_WIDTH{1'b0}}, r_regs[0]};
    assign w_b = {{DATA_WIDTH{1'b0}}, r_regs[1]};

    always_comb begin
        w_alu_res = '0;
        case (alu_func_e'(rx_data[3:0]))
            ALU_ADD:   w_alu_res = w_a + w_b;
            ALU_SUB:   w_alu_res = w_a - w_b;
            ALU_MUL:   w_alu_res = w_a * w_b;
            ALU_DIV:   w_alu_res = (w_b == '0) ? '0 : (w_a / w_b);
            ALU_AND:   w_alu_res = w_a & w_b;
            ALU_OR:    w_alu_res = w_a | w_b;
            ALU_NAND:  w_alu_res = ~(w_a & w_b);
            ALU_NOR:   w_alu_res = ~(w_a | w_b);
            ALU_XOR:   w_alu_res = w_a ^ w_b;
            ALU_XNOR:  w_alu_res = ~(w_a ^ w_b);
            ALU_CMPEQ: w_alu_res = (w_a == w_b) ? RW'(1) : '0;
            ALU_CMPGT: w_alu_res = (w_a > w_b)  ? RW'(2) : '0;
            ALU_CMPLE: w_alu_res = (w_a < w_b)  ? RW'(3) : '0;
            ALU_SHR:   w_alu_res = w_a >> 1;
            ALU_SHL:   w_alu_res = w_a << 1;
            default:   w_alu_res = '0;
        endcase
    end

    // Response pushes. The FSM needs at least two bytes between any two
    // push-producing events, so at most one push source is active per cycle.
    // A new ALU result can be registered in the same cycle the previous
    // high byte is pushed; the push still reads the old value.
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            r_rd_byte <= '0;
            r_rd_push <= 1'b0;
            r_alu_res <= '0;
            r_push_lo <= 1'b0;
            r_push_hi <= 1'b0;
        end else begin
            r_rd_push <= w_rd_req;
            if (w_rd_req) begin
                r_rd_byte <= r_regs[rx_data[ADDR_WIDTH-1:0]];
            end
            if (w_alu_go) begin
                r_alu_res <= w_alu_res;
            end
            r_push_lo <= w_alu_go;
            r_push_hi <= r_push_lo;
        end
    end

    assign w_push      = r_rd_push | r_push_lo | r_push_hi;
    assign w_push_data = r_rd_push ? r_rd_byte :
                         r_push_lo ? r_alu_res[DATA_WIDTH-1:0] :
                                     r_alu_res[RW-1:DATA_WIDTH];

    resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk         (REF_CLK),
        .rst_n       (RST),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop_ready (tx_ready),
        .o_valid     (tx_valid),
        .o_data      (tx_data)
    );

    assign cfg_uart = r_regs[2];
    assign cfg_div  = r_regs[3];

endmodule

// File: tb/tb_sys_cmd_core.sv
// -----------------------------------------------------------------------------
// tb_sys_cmd_core
// Directed, table-driven bench for sys_cmd_core with hand-computed responses,
// plus hand-written sequences for back-pressure, long gaps and reset.
// -----------------------------------------------------------------------------
module tb_sys_cmd_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] cfg_uart;
    logic [7:0] cfg_div;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] rxq [$];

    typedef struct {
        int             nb;
        logic [3:0][7:0] b;
        int             ne;
        logic [1:0][7:0] e;
        logic [7:0]     uart;
        logic [7:0]     div;
    } vec_t;

    vec_t vq [$];

    sys_cmd_core u_dut (
        .REF_CLK  (clk),
        .RST      (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cfg_uart (cfg_uart),
        .cfg_div  (cfg_div)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge, so at the falling edge a
    // valid && ready pair means the byte transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            rxq.push_back(tx_data);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic chk_rx(input string nm, input int ne, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ex [4];
        int got;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        chk({nm, " count"}, rxq.size(), ne);
        for (int k = 0; k < ne; k++) begin
            got = (k < rxq.size()) ? int'(rxq[k]) : 'h1FF;
            chk($sformatf("%s byte%0d", nm, k), got, int'(ex[k]));
        end
        rxq.delete();
    endtask

    task automatic add(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int ne,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] u, input logic [7:0] d);
        vec_t v;
        v.nb = nb; v.b = {b3, b2, b1, b0};
        v.ne = ne; v.e = {e1, e0};
        v.uart = u; v.div = d;
        vq.push_back(v);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;

        // ---------------- vector table ----------------
        add(2, 8'hBB, 8'h02, 0, 0, 1, 8'h81, 0, 8'h81, 8'h20);
        add(2, 8'hBB, 8'h03, 0, 0, 1, 8'h20, 0, 8'h81, 8'h20);
        for (int a = 0; a < 16; a++) begin
            if (a != 2 && a != 3) add(2, 8'hBB, 8'(a), 0, 0, 1, 8'h00, 0, 8'h81, 8'h20);
        end
        add(3, 8'hAA, 8'h02, 8'h23, 0, 0, 0, 0, 8'h23, 8'h20);
        add(3, 8'hAA, 8'h03, 8'h08, 0, 0, 0, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h02, 0, 0, 1, 8'h23, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h03, 0, 0, 1, 8'h08, 0, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h0A, 8'h05, 8'h00, 2, 8'h0F, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0B, 0, 0, 2, 8'h02, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0E, 0, 0, 2, 8'h14, 8'h00, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h00, 0, 0, 1, 8'h0A, 0, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h0A, 8'h05, 8'h01, 2, 8'h05, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h05, 8'h0A, 8'h01, 2, 8'hFB, 8'hFF, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h03, 0, 0, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h64, 8'h07, 8'h03, 2, 8'h0E, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h80, 8'h04, 8'h02, 2, 8'h00, 8'h02, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h80, 8'h04, 8'h0A, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h06, 0, 0, 2, 8'hFF, 8'hFF, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h03, 8'h00, 8'h03, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'hF0, 8'h0F, 8'h04, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h05, 0, 0, 2, 8'hFF, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h07, 0, 0, 2, 8'h00, 8'hFF, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h08, 0, 0, 2, 8'hFF, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h09, 0, 0, 2, 8'h00, 8'hFF, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h03, 8'h07, 8'h0C, 2, 8'h03, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0B, 0, 0, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h07, 8'h07, 8'h0A, 2, 8'h01, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0C, 0, 0, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0D, 0, 0, 2, 8'h03, 8'h00, 8'h23, 8'h08);
        add(2, 8'hDD, 8'h0F, 0, 0, 2, 8'h00, 8'h00, 8'h23, 8'h08);
        add(4, 8'hCC, 8'h80, 8'h01, 8'h0E, 2, 8'h00, 8'h01, 8'h23, 8'h08);
        add(4, 8'hCC, 8'hFF, 8'hFF, 8'h00, 2, 8'hFE, 8'h01, 8'h23, 8'h08);
        add(4, 8'hCC, 8'hFF, 8'h02, 8'h0D, 2, 8'h7F, 8'h00, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h01, 0, 0, 1, 8'h02, 0, 8'h23, 8'h08);
        for (int n = 4; n < 16; n++) begin
            add(3, 8'hAA, 8'(n), 8'(n), 0, 0, 0, 0, 8'h23, 8'h08);
        end
        add(2, 8'hBB, 8'h07, 0, 0, 1, 8'h07, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h09, 0, 0, 1, 8'h09, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h19, 0, 0, 1, 8'h09, 0, 8'h23, 8'h08);
        add(1, 8'h55, 0, 0, 0, 0, 0, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h0F, 0, 0, 1, 8'h0F, 0, 8'h23, 8'h08);
        add(3, 8'hAA, 8'hF0, 8'hC3, 0, 0, 0, 0, 8'h23, 8'h08);
        add(2, 8'hBB, 8'h00, 0, 0, 1, 8'hC3, 0, 8'h23, 8'h08);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst cfg_uart", cfg_uart, 'h81);
        chk("rst cfg_div", cfg_div, 'h20);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < vq.size(); i++) begin
            for (int k = 0; k < vq[i].nb; k++) send(vq[i].b[k], 0);
            settle();
            chk_rx($sformatf("vec%0d", i), vq[i].ne, vq[i].e[0], vq[i].e[1], 8'h00, 8'h00);
            chk($sformatf("vec%0d cfg_uart", i), cfg_uart, vq[i].uart);
            chk($sformatf("vec%0d cfg_div", i), cfg_div, vq[i].div);
        end

        // ---------------- back-pressure and overflow ----------------
        tx_ready = 1'b0;
        send(8'hCC, 0); send(8'h0A, 0); send(8'h05, 0); send(8'h00, 0);
        send(8'hBB, 0); send(8'h02, 0);
        settle();
        chk("bp held count", rxq.size(), 0);
        chk("bp tx_valid", tx_valid, 1);
        chk("bp head", tx_data, 'h0F);
        send(8'hBB, 0); send(8'h03, 0);
        send(8'hBB, 0); send(8'h07, 0);
        settle();
        chk("bp head still", tx_data, 'h0F);
        tx_ready = 1'b1;
        settle();
        chk_rx("bp release", 4, 8'h0F, 8'h00, 8'h23, 8'h08);
        chk("bp drained", tx_valid, 0);
        send(8'hBB, 0); send(8'h09, 0);
        settle();
        chk_rx("bp after", 1, 8'h09, 8'h00, 8'h00, 8'h00);

        // ---------------- long gaps ----------------
        send(8'hCC, 1000); send(8'h0A, 1000); send(8'h05, 1000); send(8'h00, 0);
        settle();
        chk_rx("gap alu", 2, 8'h0F, 8'h00, 8'h00, 8'h00);
        send(8'hBB, 1000); send(8'h02, 0);
        settle();
        chk_rx("gap rd", 1, 8'h23, 8'h00, 8'h00, 8'h00);

        // ---------------- reset mid-sequence ----------------
        tx_ready = 1'b0;
        send(8'hBB, 0); send(8'h03, 0);
        send(8'hAA, 0); send(8'h02, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #2;
        chk("mid rst tx_valid", tx_valid, 0);
        chk("mid rst cfg_uart", cfg_uart, 'h81);
        chk("mid rst cfg_div", cfg_div, 'h20);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        send(8'h33, 0);
        settle();
        chk_rx("post rst idle", 0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("post rst cfg_uart", cfg_uart, 'h81);
        send(8'hBB, 0); send(8'h02, 0);
        send(8'hBB, 0); send(8'h05, 0);
        settle();
        chk_rx("post rst rd", 2, 8'h81, 8'h00, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sys_cmd_core.md
Name: sys_cmd_core

Overview:
- Single-clock command processor at the heart of the UART-controlled system, between the UART RX/TX byte interfaces and the rest of the chip.
- Decodes received command bytes and executes register-file reads and writes, and ALU operations.
- Queues response bytes for the UART transmitter.
- Exports the UART config register (reg2) and clock-divider register (reg3).

Parameters:
- DATA_WIDTH, 8, byte width of the RX/TX/register data path.
- ADDR_WIDTH, 4, register-file address width.
- REG_NO, 16, number of registers.
- FIFO_DEPTH, 4, response byte queue depth (power of 2).

Ports:
- REF_CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from UART RX.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- tx_data  out  8  response byte to UART TX.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  UART TX can accept; a byte transfers when tx_valid && tx_ready.
- cfg_uart  out  8  reg2 contents: bit0 parity enable, bit1 parity odd(1)/even(0), bits7:2 prescale.
- cfg_div  out  8  reg3 contents: UART clock division ratio.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM returns to IDLE and the FIFO is emptied.
  - tx_valid=0, tx_data=0.
  - reg0, reg1 and reg4..15 = 0x00.
  - reg2=0x81 (parity enabled, even, prescale 32); reg3=0x20.
- Commands (first byte of a sequence):
  - 0xAA RF write: ADDR, DATA.
  - 0xBB RF read: ADDR.
  - 0xCC ALU with operands: A, B, FUNC.
  - 0xDD ALU without operands: FUNC.
- Any other byte received in IDLE is ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC.
  - States advance only on rx_valid.
  - The state after the final byte of a sequence is IDLE.
  - There is no timeout; arbitrary gaps between bytes are legal.
- Address field: ADDR[3:0] is used and ADDR[7:4] is ignored.
- RF write: reg[ADDR] <= DATA on the rx_valid cycle of the DATA byte. All 16 addresses are writable, including reg0–3.
- RF read: reg[ADDR] is pushed to the FIFO on the cycle after the ADDR byte.
- ALU operands:
  - For 0xCC, byte A is written to reg0 and byte B to reg1 as each arrives.
  - For 0xDD, the current reg0 and reg1 are used.
  - The func byte uses FUNC[3:0].
- ALU result is 16 bits, with A = reg0 and B = reg1. Functions:
  - 0 ADD
  - 1 SUB (A−B, 16-bit two's complement)
  - 2 MUL
  - 3 DIV (B=0 gives 0)
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR
  - 10 CMPEQ (1 if A==B, else 0)
  - 11 CMPGT (2 if A>B, else 0)
  - 12 CMPLE (3 if A<B, else 0)
  - 13 SHR (A>>1)
  - 14 SHL (A<<1)
  - 15 gives 0
- Operands are zero-extended to 16 bits before any operation. Logical results are 16-bit, so NAND of 8-bit values has upper byte 0xFF.
- ALU result timing:
  - The result is registered on the FUNC byte cycle.
  - The low byte is pushed the next cycle, then the high byte the cycle after.
  - FSM is back in IDLE after the FUNC byte; rx_valid during the push cycles is still decoded normally.
- FIFO:
  - Push and pop in the same cycle are both allowed.
  - Pushes while full are dropped.
  - tx_valid = !empty, and tx_data = head entry.
  - Pop occurs on tx_valid && tx_ready.
- Order: response bytes leave in push order, and processing continues while TX is busy.
- cfg_uart and cfg_div are continuous views of reg2 and reg3.

Decomposition:
- Shared package holds:
  - command codes CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - ALU function enum (ADD..SHL = 0..14);
  - FSM state typedef;
  - reg2/reg3 reset constants.
- One sub-module, resp_fifo: synchronous byte FIFO with valid/ready pop. The register file and ALU stay inline.

Test Plan:
- Reset, then read reg2 and reg3 -> 0x81 then 0x20 on tx_data; all other registers read 0x00.
- AA 02 23, AA 03 08, then BB 02, BB 03 -> cfg_uart=0x23, cfg_div=0x08, TX bytes 0x23, 0x08.
- CC 0A 05 00 (ADD) -> TX 0x0F, 0x00; then DD 0B (CMPGT) -> 0x02, 0x00; DD 0E (SHL) -> 0x14, 0x00; BB 00 -> 0x0A.
- CC 80 04 02 (MUL) -> 0x00, 0x02; CC 80 04 0A (CMPEQ) -> 0x00, 0x00; DD 06 (NAND) -> 0xFF, 0xFF; CC 03 00 03 (DIV by 0) -> 0x00, 0x00.
- AA n n for n=4..15, then BB 07, BB 09 -> 0x07, 0x09. A stray 0x55 in IDLE produces no response.
- Hold tx_ready=0 during an ALU op plus a read -> 3 bytes queued, then released in order. Bytes separated by 1000-cycle gaps give the same results. RST pulse mid-sequence -> IDLE, FIFO empty, registers back to reset values.
